// File: rtl/coin_acceptor.sv
// Vending front end: coin credit accumulation, vend/cancel handling and held change handshake.
// Optional idle auto-refund is built when COIN_TIMEOUT_EN is defined.
module coin_acceptor #(
    parameter int CREDIT_MAX     = 100,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_nickel,
    input  logic       coin_dime,
    input  logic       coin_quarter,
    input  logic [6:0] price,
    input  logic       vend_req,
    input  logic       cancel,
    input  logic       change_ack,
    output logic [6:0] credit,
    output logic [6:0] change,
    output logic       change_valid,
    output logic       vend,
    output logic       coin_reject,
    output logic       vend_err
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_PAYOUT  = 2'd2;
    localparam logic [7:0] CMAX      = 8'(CREDIT_MAX);

    logic [1:0] state;
    logic [1:0] coin_cnt;
    logic       coin_any;
    logic       coin_multi;
    logic [6:0] coin_val;
    logic [7:0] coin_sum;
    logic       price_bad;
    logic       timeout;
    logic       do_cancel;

    assign coin_cnt   = {1'b0, coin_nickel} + {1'b0, coin_dime} + {1'b0, coin_quarter};
    assign coin_any   = coin_nickel | coin_dime | coin_quarter;
    assign coin_multi = (coin_cnt >= 2'd2);

    always_comb begin
        coin_val = 7'd0;
        if (coin_quarter)     coin_val = 7'd25;
        else if (coin_dime)   coin_val = 7'd10;
        else if (coin_nickel) coin_val = 7'd5;
    end

    // One bit wider so a coin on top of a high credit cannot wrap before the limit check
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    assign price_bad = (price == 7'd0) || ((price % 7'd5) != 7'd0) ||
                       ({1'b0, price} > CMAX) || (credit < price);

`ifdef COIN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;

    assign timeout = (state == S_COLLECT) && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (state != S_COLLECT || coin_any || vend_req || cancel || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign do_cancel = cancel | timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            credit       <= 7'd0;
            change       <= 7'd0;
            change_valid <= 1'b0;
            vend         <= 1'b0;
            coin_reject  <= 1'b0;
            vend_err     <= 1'b0;
        end else begin
            vend        <= 1'b0;
            coin_reject <= 1'b0;
            vend_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vend_req) begin
                        vend_err    <= 1'b1;
                        coin_reject <= coin_any;
                    end else if (coin_multi) begin
                        coin_reject <= 1'b1;
                    end else if (coin_any) begin
                        if (coin_sum <= CMAX) begin
                            credit <= coin_sum[6:0];
                            state  <= S_COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (do_cancel) begin
                        change       <= credit;
                        credit       <= 7'd0;
                        change_valid <= 1'b1;
                        coin_reject  <= coin_any;
                        state        <= S_PAYOUT;
                    end else if (vend_req) begin
                        coin_reject <= coin_any;
                        if (price_bad) begin
                            vend_err <= 1'b1;
                        end else begin
                            vend   <= 1'b1;
                            credit <= 7'd0;
                            if (credit > price) begin
                                change       <= credit - price;
                                change_valid <= 1'b1;
                                state        <= S_PAYOUT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end else if (coin_multi) begin
                        coin_reject <= 1'b1;
                    end else if (coin_any) begin
                        if (coin_sum <= CMAX) credit <= coin_sum[6:0];
                        else                  coin_reject <= 1'b1;
                    end
                end
                S_PAYOUT: begin
                    coin_reject <= coin_any;
                    if (change_valid && change_ack) begin
                        change_valid <= 1'b0;
                        change       <= 7'd0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, corner sequences, randomized run against a credit/change model.
module tb_coin_acceptor;
    localparam int TMO  = 8;
    localparam int CMAX = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_nickel = 1'b0, coin_dime = 1'b0, coin_quarter = 1'b0;
    logic [6:0] price = 7'd0;
    logic       vend_req = 1'b0, cancel = 1'b0, change_ack = 1'b0;
    logic [6:0] credit, change;
    logic       change_valid, vend, coin_reject, vend_err;

    coin_acceptor #(.CREDIT_MAX(CMAX), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .coin_nickel(coin_nickel), .coin_dime(coin_dime), .coin_quarter(coin_quarter),
        .price(price), .vend_req(vend_req), .cancel(cancel), .change_ack(change_ack),
        .credit(credit), .change(change), .change_valid(change_valid),
        .vend(vend), .coin_reject(coin_reject), .vend_err(vend_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else passed++;
    endtask

    typedef struct packed {
        logic       n, d, q;
        logic [6:0] pr;
        logic       vr, cc, ak;
        int         cr, chg;
        logic       cv, vd, rj, er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic n, logic d, logic q, int pr, logic vr, logic cc, logic ak,
                                int cr, int chg, logic cv, logic vd, logic rj, logic er);
        vec_t v;
        v.n = n; v.d = d; v.q = q; v.pr = 7'(pr); v.vr = vr; v.cc = cc; v.ak = ak;
        v.cr = cr; v.chg = chg; v.cv = cv; v.vd = vd; v.rj = rj; v.er = er;
        return v;
    endfunction

    // Inputs are applied just after an edge and held across the next one
    task automatic drive(input logic n, d, q, input int pr, input logic vr, cc, ak);
        coin_nickel = n; coin_dime = d; coin_quarter = q;
        price = 7'(pr); vend_req = vr; cancel = cc; change_ack = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int cr, chg, input logic cv, vd, rj, er);
        check({tag, ".credit"}, int'(credit), cr);
        check({tag, ".change"}, int'(change), chg);
        check({tag, ".change_valid"}, int'(change_valid), int'(cv));
        check({tag, ".vend"}, int'(vend), int'(vd));
        check({tag, ".coin_reject"}, int'(coin_reject), int'(rj));
        check({tag, ".vend_err"}, int'(vend_err), int'(er));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        coin_nickel = 0; coin_dime = 0; coin_quarter = 0;
        vend_req = 0; cancel = 0; change_ack = 0; price = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Reference: credit held while collecting; pending change means payout.
    int m_credit, m_chg, m_idle;
    bit m_cv, m_vend, m_rej, m_err;

    task automatic model_reset();
        m_credit = 0; m_chg = 0; m_cv = 0; m_vend = 0; m_rej = 0; m_err = 0; m_idle = 0;
    endtask

    task automatic model_step(input logic n, d, q, input int pr, input logic vr, cc, ak);
        int nc, val;
        bit coll, fire, ev;
        nc   = int'(n) + int'(d) + int'(q);
        val  = q ? 25 : (d ? 10 : (n ? 5 : 0));
        coll = (m_credit > 0) && !m_cv;
        ev   = (nc > 0) || vr || cc;
        fire = 0;
`ifdef COIN_TIMEOUT_EN
        fire = coll && (m_idle == TMO - 1);
`endif
        m_vend = 0; m_rej = 0; m_err = 0;
        if (m_cv) begin
            m_rej = (nc > 0);
            if (ak) begin m_cv = 0; m_chg = 0; end
        end else if ((cc || fire) && coll) begin
            m_chg = m_credit; m_credit = 0; m_cv = 1; m_rej = (nc > 0);
        end else if (vr) begin
            m_rej = (nc > 0);
            if (!coll || pr == 0 || (pr % 5) != 0 || pr > CMAX || m_credit < pr) m_err = 1;
            else begin
                m_vend = 1;
                if (m_credit > pr) begin m_chg = m_credit - pr; m_cv = 1; end
                m_credit = 0;
            end
        end else if (nc >= 2) begin
            m_rej = 1;
        end else if (nc == 1) begin
            if (m_credit + val <= CMAX) m_credit += val;
            else m_rej = 1;
        end
        if (coll && !ev && !fire) m_idle++;
        else m_idle = 0;
    endtask

    initial begin
        do_reset();
        check_outs("reset", 0, 0, 0, 0, 0, 0);

        //            n d q  pr  vr cc ak  cr  chg cv vd rj er
        tbl.push_back(mk(0,0,1,  0, 0,0,0,  25,  0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,  0, 0,0,0,  35,  0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,  0, 0,0,0,  40,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 15, 1,0,0,   0, 25, 1,1,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,0,   0, 25, 1,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,1,   0,  0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,  0, 0,0,0,  10,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 25, 1,0,0,  10,  0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,  0, 0,1,0,   0, 10, 1,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,1,   0,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,  0, 0,0,0,  25,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,  0, 0,0,0,  50,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,  0, 0,0,0,  75,  0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,  0, 0,0,0,  85,  0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,  0, 0,0,0,  90,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,  0, 0,0,0,  90,  0, 0,0,1,0));
        tbl.push_back(mk(1,1,0,  0, 0,0,0,  90,  0, 0,0,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,0,0, 100,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,1,0,   0,100, 1,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,1,   0,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,  0, 0,0,0,  25,  0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,  0, 0,0,0,  30,  0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 30, 1,0,0,   0,  0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,0,   0,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,  5, 1,0,0,   0,  0, 0,0,0,1));
        tbl.push_back(mk(0,1,0,  0, 0,0,0,  10,  0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,  0, 0,0,0,  20,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,  7, 1,0,0,  20,  0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,  0, 1,0,0,  20,  0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,105, 1,0,0,  20,  0, 0,0,0,1));
        tbl.push_back(mk(0,0,0, 10, 1,1,0,   0, 20, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 10, 1,0,0,   0, 20, 1,0,1,0));
        tbl.push_back(mk(0,0,0,  0, 0,1,0,   0, 20, 1,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,1,   0,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,0,1,   0,  0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,  5, 1,0,0,   0,  0, 0,0,0,1));

        foreach (tbl[i]) begin
            drive(tbl[i].n, tbl[i].d, tbl[i].q, int'(tbl[i].pr), tbl[i].vr, tbl[i].cc, tbl[i].ak);
            check_outs($sformatf("vec%0d", i), tbl[i].cr, tbl[i].chg, tbl[i].cv,
                       tbl[i].vd, tbl[i].rj, tbl[i].er);
        end

        // Ack high while vending: ignored that cycle, acted on the next
        drive(0,1,0, 0, 0,0,0);
        drive(0,0,0, 5, 1,0,1);
        check_outs("ackrise", 0, 5, 1, 1, 0, 0);
        drive(0,0,0, 0, 0,0,1);
        check_outs("ackrise2", 0, 0, 0, 0, 0, 0);

`ifdef COIN_TIMEOUT_EN
        drive(1,0,0, 0, 0,0,0);
        for (int k = 1; k < TMO; k++) begin
            drive(0,0,0, 0, 0,0,0);
            check($sformatf("tmo_wait%0d", k), int'(change_valid), 0);
        end
        drive(0,0,0, 0, 0,0,0);
        check_outs("tmo_fire", 0, 5, 1, 0, 0, 0);
        drive(0,0,0, 0, 0,0,1);
`endif

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic n, d, q, vr, cc, ak;
            int pr;
            n  = ($urandom_range(0, 99) < 15);
            d  = ($urandom_range(0, 99) < 15);
            q  = ($urandom_range(0, 99) < 12);
            vr = ($urandom_range(0, 99) < 8);
            cc = ($urandom_range(0, 99) < 4);
            ak = ($urandom_range(0, 99) < 30);
            pr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 127))
                                             : 5 * int'($urandom_range(1, 20));
            drive(n, d, q, pr, vr, cc, ak);
            model_step(n, d, q, pr, vr, cc, ak);
            check_outs($sformatf("rnd%0d", c), m_credit, m_chg, m_cv, m_vend, m_rej, m_err);
        end

        // Asynchronous reset in the middle of a payout
        drive(0,0,0, 0, 0,0,1);
        drive(0,0,0, 0, 0,0,1);
        drive(0,1,0, 0, 0,0,0);
        drive(0,0,0, 0, 0,1,0);
        check("pre_rst.change_valid", int'(change_valid), 1);
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0,0,1, 0, 0,0,0);
        check_outs("post_rst", 25, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
